// File: rtl/jtkicker_pkg.sv
// Shared definitions for the Kicker object RAM arbiter: FSM states and data width.
package jtkicker_pkg;

    localparam int unsigned OBJ_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU_RD,
        ST_CPU_WR,
        ST_RDWAIT
    } obj_st_e;

endpackage

// File: rtl/jtkicker_objbank.sv
// Object RAM bank selection: LVBL falling-edge sampling of obj_frame with the swap held off while a transfer is in flight.
// JTKICKER_OBJ_DBUF_EN enables double buffering; otherwise both sides use bank 0.
module jtkicker_objbank (
    input  logic clk,
    input  logic rstn,
    input  logic lvbl,
    input  logic obj_frame,
    input  logic busy,
    output logic cpu_bank,
    output logic vid_bank
);

`ifdef JTKICKER_OBJ_DBUF_EN
    logic lvbl_l;
    logic swap_pend;
    logic frame_l;
    logic lvbl_fall_c;
    logic swap_c;
    logic frame_c;

    // A pending swap keeps the frame captured at the edge, not the live latch value
    always_comb begin
        lvbl_fall_c = lvbl_l & ~lvbl;
        frame_c     = lvbl_fall_c ? obj_frame : frame_l;
        swap_c      = (lvbl_fall_c | swap_pend) & ~busy;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvbl_l    <= 1'b0;
            swap_pend <= 1'b0;
            frame_l   <= 1'b0;
            cpu_bank  <= 1'b0;
            vid_bank  <= 1'b1;
        end else begin
            lvbl_l <= lvbl;
            if (lvbl_fall_c) frame_l <= obj_frame;
            if (swap_c) begin
                cpu_bank  <= frame_c;
                vid_bank  <= ~frame_c;
                swap_pend <= 1'b0;
            end else if (lvbl_fall_c) begin
                swap_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rstn, lvbl, obj_frame, busy};
    assign cpu_bank  = 1'b0;
    assign vid_bank  = 1'b0;
`endif

endmodule

// File: rtl/jtkicker_objarb.sv
// Object RAM arbiter between the 6809 bus and the object line scanner, with CPU starvation limit.
// JTKICKER_OBJ_DBUF_EN selects double-buffered banks (see jtkicker_objbank).
module jtkicker_objarb
    import jtkicker_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned CPU_MAXW = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_cen,
    input  logic              cpu_cs,
    input  logic              cpu_rnw,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [OBJ_DW-1:0] cpu_wdata,
    output logic [OBJ_DW-1:0] cpu_rdata,
    output logic              cpu_wait,
    input  logic              obj_frame,
    input  logic              LVBL,
    input  logic              vid_req,
    input  logic [AW-1:0]     vid_addr,
    output logic [OBJ_DW-1:0] vid_rdata,
    output logic              vid_ok,
    output logic [AW:0]       ram_addr,
    output logic [OBJ_DW-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [OBJ_DW-1:0] ram_rdata
);

    localparam int unsigned SW = (CPU_MAXW < 1) ? 1 : $clog2(CPU_MAXW + 1);

    obj_st_e           state, state_nxt;
    logic              rd_cpu, rd_cpu_nxt;
    logic [SW-1:0]     starve, starve_nxt;
    logic              req_rnw;
    logic [AW-1:0]     req_addr;
    logic [OBJ_DW-1:0] req_wdata;
    logic              latch_c;
    logic              busy_c;
    logic              cpu_bank;
    logic              vid_bank;

    logic [OBJ_DW-1:0] cpu_rdata_nxt, vid_rdata_nxt, ram_wdata_nxt;
    logic [AW:0]       ram_addr_nxt;
    logic              cpu_wait_nxt, vid_ok_nxt, ram_we_nxt;

    assign latch_c = cpu_cen & cpu_cs & ~cpu_wait;
    assign busy_c  = (state != ST_IDLE);

    jtkicker_objbank u_bank (
        .clk       (clk),
        .rstn      (rstn),
        .lvbl      (LVBL),
        .obj_frame (obj_frame),
        .busy      (busy_c),
        .cpu_bank  (cpu_bank),
        .vid_bank  (vid_bank)
    );

    // Next state and registered outputs; cpu_wait doubles as the CPU pending flag
    always_comb begin
        state_nxt     = state;
        rd_cpu_nxt    = rd_cpu;
        starve_nxt    = starve;
        cpu_rdata_nxt = cpu_rdata;
        vid_rdata_nxt = vid_rdata;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        cpu_wait_nxt  = cpu_wait | latch_c;
        vid_ok_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_wait && (!vid_req || starve == SW'(CPU_MAXW))) begin
                    ram_addr_nxt = {cpu_bank, req_addr};
                    starve_nxt   = '0;
                    if (req_rnw) begin
                        state_nxt = ST_CPU_RD;
                    end else begin
                        state_nxt     = ST_CPU_WR;
                        ram_we_nxt    = 1'b1;
                        ram_wdata_nxt = req_wdata;
                    end
                end else if (vid_req) begin
                    state_nxt    = ST_VID;
                    ram_addr_nxt = {vid_bank, vid_addr};
                    if (cpu_wait) starve_nxt = starve + SW'(1);
                end
            end
            ST_VID: begin
                state_nxt  = ST_RDWAIT;
                rd_cpu_nxt = 1'b0;
            end
            ST_CPU_RD: begin
                state_nxt  = ST_RDWAIT;
                rd_cpu_nxt = 1'b1;
            end
            ST_CPU_WR: begin
                state_nxt    = ST_IDLE;
                cpu_wait_nxt = 1'b0;
            end
            ST_RDWAIT: begin
                state_nxt = ST_IDLE;
                if (rd_cpu) begin
                    cpu_rdata_nxt = ram_rdata;
                    cpu_wait_nxt  = 1'b0;
                end else begin
                    vid_rdata_nxt = ram_rdata;
                    vid_ok_nxt    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            rd_cpu    <= 1'b0;
            starve    <= '0;
            req_rnw   <= 1'b1;
            req_addr  <= '0;
            req_wdata <= '0;
            cpu_rdata <= '0;
            cpu_wait  <= 1'b0;
            vid_rdata <= '0;
            vid_ok    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_cpu    <= rd_cpu_nxt;
            starve    <= starve_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            cpu_wait  <= cpu_wait_nxt;
            vid_rdata <= vid_rdata_nxt;
            vid_ok    <= vid_ok_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            ram_we    <= ram_we_nxt;
            if (latch_c) begin
                req_rnw   <= cpu_rnw;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_objarb.sv
// Bench for jtkicker_objarb: directed timing/bank checks plus randomized CPU/scanner traffic against a memory model.
module tb_jtkicker_objarb;

    localparam int AW    = 10;
    localparam int AW1   = AW + 1;
    localparam int MAXW  = 3;
    localparam int DEPTH = 2 ** AW1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_cen, cpu_cs, cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          cpu_wait;
    logic          obj_frame, LVBL;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_rdata;
    logic          vid_ok;
    logic [AW:0]   ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;
    logic          ram_we;

    // external RAM with preload port used only during reset
    logic [7:0]    ram [DEPTH];
    logic          pl_en;
    logic [AW:0]   pl_idx;
    logic [7:0]    pl_val;

    // reference model: flat memory image and current bank assignment
    logic [7:0]    ref_mem [DEPTH];
    logic          ref_cpu_bank, ref_vid_bank;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_val;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    jtkicker_objarb #(.AW(AW), .CPU_MAXW(MAXW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_cen   (cpu_cen),
        .cpu_cs    (cpu_cs),
        .cpu_rnw   (cpu_rnw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait),
        .obj_frame (obj_frame),
        .LVBL      (LVBL),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_ok    (vid_ok),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_cpu_bank = 1'b0;
`ifdef JTKICKER_OBJ_DBUF_EN
        ref_vid_bank = 1'b1;
`else
        ref_vid_bank = 1'b0;
`endif
    endtask

    // One CPU access from a negedge; returns clocks cpu_wait was seen high
    task automatic cpu_access(input logic rnw, input logic [AW-1:0] a, input logic [7:0] wd, output int cyc);
        int we_cnt;
        int idx;
        cpu_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_wdata = wd;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_cen = 1'b0;
        chk("wait_rise", 32'(cpu_wait), 32'd1);
        cyc = 0; we_cnt = 0;
        while (cpu_wait === 1'b1 && cyc < 64) begin
            if (ram_we) begin
                we_cnt++;
                chk("we_data", 32'(ram_wdata), 32'(wd));
            end
            cyc++;
            @(negedge clk);
        end
        chk("wait_timeout", 32'(cpu_wait), 32'd0);
        idx = int'({ref_cpu_bank, a});
        chk("cpu_ram_addr", 32'(ram_addr), 32'(idx));
        chk("we_count", 32'(we_cnt), rnw ? 32'd0 : 32'd1);
        if (rnw) chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[idx]));
        else ref_mem[idx] = wd;
    endtask

    // One scanner read from a negedge; returns clocks until vid_ok seen
    task automatic vid_read(input logic [AW-1:0] a, output int lat);
        int idx;
        vid_req = 1'b1; vid_addr = a; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (vid_ok !== 1'b1 && lat < 64);
        vid_req = 1'b0;
        chk("vid_ok_seen", 32'(vid_ok), 32'd1);
        idx = int'({ref_vid_bank, a});
        chk("vid_ram_addr", 32'(ram_addr), 32'(idx));
        chk("vid_rdata", 32'(vid_rdata), 32'(ref_mem[idx]));
    endtask

    // CPU read raised with the scanner requesting back to back
    task automatic starve_run(input logic [AW-1:0] a, input logic [AW-1:0] v);
        int cyc;
        int pulses;
        repeat (6) @(negedge clk);
        cpu_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_cen = 1'b0;
        vid_req = 1'b1; vid_addr = v;
        cyc = 0; pulses = 0;
        while (cpu_wait === 1'b1 && cyc < 64) begin
            if (vid_ok) begin
                pulses++;
                chk("starve_vid_data", 32'(vid_rdata), 32'(ref_mem[int'({ref_vid_bank, v})]));
            end
            cyc++;
            @(negedge clk);
        end
        vid_req = 1'b0;
        chk("starve_pulses", 32'(pulses), 32'(MAXW));
        chk("starve_stall", 32'(cyc), 32'(MAXW * 3 + 3));
        chk("starve_rdata", 32'(cpu_rdata), 32'(ref_mem[int'({ref_cpu_bank, a})]));
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lat;
        int pulses;
        logic [7:0] old;
        rstn = 1'b0; cpu_cen = 1'b0; cpu_cs = 1'b0; cpu_rnw = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; obj_frame = 1'b0; LVBL = 1'b1;
        vid_req = 1'b0; vid_addr = '0; pl_en = 1'b1; pl_idx = '0; pl_val = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pl_idx = AW1'(i);
            pl_val = 8'($urandom);
            ref_mem[i] = pl_val;
        end
        @(negedge clk);
        pl_en = 1'b0;
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_cpu_wait",  32'(cpu_wait),  32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        chk("rst_vid_ok",    32'(vid_ok),    32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ram_addr", 32'(ram_addr), 32'd0);
        chk("idle_cpu_wait", 32'(cpu_wait), 32'd0);

        // chip select without the Q-clock enable must not start an access
        cpu_cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("cen_gate", 32'(cpu_wait), 32'd0);
        cpu_cs = 1'b0;
        @(negedge clk);

        cpu_access(1'b0, 10'h123, 8'h5A, cyc);
        chk("wr_wait_clk", 32'(cyc), 32'd2);
        cpu_access(1'b1, 10'h123, 8'h00, cyc);
        chk("rd_wait_clk", 32'(cyc), 32'd3);
        chk("rd_5a", 32'(cpu_rdata), 32'h5A);

        vid_read(10'h300, lat);
        chk("vid_latency", 32'(lat), 32'd3);

        // request withdrawn right after the grant still yields one pulse
        vid_req = 1'b1; vid_addr = 10'h2F0;
        @(negedge clk);
        vid_req = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (vid_ok) pulses++;
        end
        chk("drop_pulse", 32'(pulses), 32'd1);

        starve_run(10'h123, 10'h3A0);
        starve_run(10'h055, 10'h3A1);

        // LVBL falls while a write is on the RAM: write keeps the old bank
        obj_frame = 1'b1;
        cpu_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h040; cpu_wdata = 8'hC3;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_cen = 1'b0;
        @(negedge clk);
        chk("bank_we", 32'(ram_we), 32'd1);
        chk("bank_wr_addr", 32'(ram_addr), 32'(int'({1'b0, cpu_addr})));
        ref_mem[int'({ref_cpu_bank, cpu_addr})] = 8'hC3;
        LVBL = 1'b0;
        @(negedge clk);
        chk("bank_wait", 32'(cpu_wait), 32'd0);
        @(negedge clk);
        LVBL = 1'b1;
`ifdef JTKICKER_OBJ_DBUF_EN
        ref_cpu_bank = 1'b1; ref_vid_bank = 1'b0;
`endif
        cpu_access(1'b1, 10'h040, 8'h00, cyc);
        chk("bank_cpu_msb", 32'(ram_addr[AW]), 32'(ref_cpu_bank));
        vid_read(10'h040, lat);
        chk("bank_vid_c3", 32'(vid_rdata), 32'hC3);

        // second frame flip at idle, obj_frame back to 0
        obj_frame = 1'b0; LVBL = 1'b0;
        repeat (2) @(negedge clk);
        LVBL = 1'b1;
`ifdef JTKICKER_OBJ_DBUF_EN
        ref_cpu_bank = 1'b0; ref_vid_bank = 1'b1;
`endif
        cpu_access(1'b0, 10'h041, 8'h9E, cyc);
        vid_read(10'h200, lat);
`ifndef JTKICKER_OBJ_DBUF_EN
        chk("single_msb", 32'(ram_addr[AW]), 32'd0);
`endif

        // concurrent random traffic: CPU in lower half, scanner in upper half
        fork
            begin
                int c;
                logic [7:0] d;
                for (int k = 0; k < 30; k++) begin
                    d = 8'($urandom);
                    cpu_access(1'($urandom), AW'($urandom_range(0, 511)), d, c);
                    chk("stall_bound", 32'(c <= (MAXW + 1) * 3 + 2), 32'd1);
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                end
            end
            begin
                int l;
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    vid_read(AW'($urandom_range(512, 1023)), l);
                end
            end
        join
        repeat (4) @(negedge clk);

        // reset lands while the write strobe is high: no write reaches the RAM
        old = ref_mem[int'({ref_cpu_bank, 10'h077})];
        cpu_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h077; cpu_wdata = ~old;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_cen = 1'b0;
        @(negedge clk);
        chk("rst_we_pre", 32'(ram_we), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_we_now", 32'(ram_we), 32'd0);
        chk("rst_wait_now", 32'(cpu_wait), 32'd0);
        chk("rst_addr_now", 32'(ram_addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        cpu_access(1'b1, 10'h077, 8'h00, cyc);
        chk("rst_no_write", 32'(cpu_rdata), 32'(old));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
